pc_hazard_ctrl: RTL and testbench

- Hazard and PC-select controller for the 5-stage RISC-V pipeline. Generates Do_Stall and Is_Branch_Taken for the PC mux.
- Also generates the IF/ID flush and ID/EX bubble controls.
- Sequences load-use stalls, multi-cycle data-memory waits and EX-stage branch redirects.
- Keeps saturating stall/flush performance counters.

---
 rtl/pipe_pkg.sv | 40 ++++
 rtl/pc_hazard_ctrl_sat_counter.sv | 34 +++
 rtl/pc_hazard_ctrl.sv | 132 +++++++++++++
 tb/tb_pc_hazard_ctrl.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared pipeline-control definitions: hazard FSM states, register constants
// and the PC-mux select encoding used by both the PC mux and the hazard unit.
package pipe_pkg;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_LU_STALL = 2'd1,
    ST_MEM_WAIT = 2'd2
  } hz_state_e;

  localparam logic [4:0] REG_X0 = 5'd0;

  typedef enum logic [1:0] {
    SEL_SEQ    = 2'd0,
    SEL_HOLD   = 2'd1,
    SEL_BRANCH = 2'd2
  } pc_sel_e;

  // Control bundle produced by the hazard unit each cycle.
  typedef struct packed {
    logic stall;
    logic taken;
    logic flush;
    logic bubble;
  } hz_ctrl_t;

  // PC-mux view of the controller outputs; a stall always wins so that the
  // illegal {taken, stall} = 11 combination can never select a branch.
  function automatic pc_sel_e pc_sel(input logic stall, input logic taken);
    pc_sel_e sel;
    sel = SEL_SEQ;
    if (stall) begin
      sel = SEL_HOLD;
    end else if (taken) begin
      sel = SEL_BRANCH;
    end
    return sel;
  endfunction

endpackage

// File: rtl/pc_hazard_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear; clear beats increment.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         Clk,
  input  logic         Rst_N,
  input  logic         Clr,
  input  logic         Inc,
  output logic [W-1:0] Count
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (Clr) begin
      count_d = '0;
    end else if (Inc && (count_q != {W{1'b1}})) begin
      count_d = count_q + {{(W-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge Clk or negedge Rst_N) begin
    if (!Rst_N) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign Count = count_q;

endmodule

// File: rtl/pc_hazard_ctrl.sv
// Hazard / PC-select controller: load-use stalls, data-memory freezes and
// EX-stage branch redirects, with saturating stall/flush counters.
module pc_hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int unsigned LOAD_USE_CYCLES = 1,
  parameter int unsigned CNT_W           = 16
) (
  input  logic             Clk,
  input  logic             Rst_N,
  input  logic [4:0]       Id_Rs1,
  input  logic [4:0]       Id_Rs2,
  input  logic             Id_Uses_Rs1,
  input  logic             Id_Uses_Rs2,
  input  logic [4:0]       Ex_Rd,
  input  logic             Ex_Mem_Read,
  input  logic             Ex_Branch_Valid,
  input  logic             Ex_Branch_Cond,
  input  logic             Dmem_Busy,
  input  logic             Perf_Clr,
  output logic             Do_Stall,
  output logic             Is_Branch_Taken,
  output logic             Flush_If_Id,
  output logic             Bubble_Id_Ex,
  output logic [CNT_W-1:0] Stall_Count,
  output logic [CNT_W-1:0] Flush_Count
);

  localparam logic [2:0] LU_INIT = 3'(LOAD_USE_CYCLES - 1);

  hz_state_e  state_q, state_d;
  logic [2:0] lu_cnt_q, lu_cnt_d;
  hz_ctrl_t   ctrl;
  hz_ctrl_t   ctrl_out;
  logic       load_use;
  logic       taken;
  logic       eval_run;

  assign load_use = Ex_Mem_Read && (Ex_Rd != REG_X0) &&
                    ((Id_Uses_Rs1 && (Id_Rs1 == Ex_Rd)) ||
                     (Id_Uses_Rs2 && (Id_Rs2 == Ex_Rd)));
  assign taken    = Ex_Branch_Valid && Ex_Branch_Cond;

  always_comb begin
    ctrl     = '0;
    state_d  = state_q;
    lu_cnt_d = lu_cnt_q;
    eval_run = 1'b0;

    case (state_q)
      ST_LU_STALL: begin
        // EX holds a bubble here, so any branch presented is spurious and ignored.
        ctrl.stall  = 1'b1;
        ctrl.bubble = 1'b1;
        if (!Dmem_Busy) begin
          if (lu_cnt_q <= 3'd1) begin
            state_d  = ST_RUN;
            lu_cnt_d = 3'd0;
          end else begin
            lu_cnt_d = lu_cnt_q - 3'd1;
          end
        end
      end
      ST_MEM_WAIT: begin
        if (Dmem_Busy) begin
          ctrl.stall = 1'b1;
        end else begin
          eval_run = 1'b1;
        end
      end
      default: begin
        eval_run = 1'b1;
      end
    endcase

    // Exit from MEM_WAIT falls through here in the same cycle, so a branch
    // held in EX during the freeze redirects exactly once.
    if (eval_run) begin
      state_d = ST_RUN;
      if (Dmem_Busy) begin
        ctrl.stall = 1'b1;
        state_d    = ST_MEM_WAIT;
      end else if (taken) begin
        ctrl.taken  = 1'b1;
        ctrl.flush  = 1'b1;
        ctrl.bubble = 1'b1;
      end else if (load_use) begin
        ctrl.stall  = 1'b1;
        ctrl.bubble = 1'b1;
        if (LOAD_USE_CYCLES > 1) begin
          state_d  = ST_LU_STALL;
          lu_cnt_d = LU_INIT;
        end
      end
    end
  end

  always_ff @(posedge Clk or negedge Rst_N) begin
    if (!Rst_N) begin
      state_q  <= ST_RUN;
      lu_cnt_q <= 3'd0;
    end else begin
      state_q  <= state_d;
      lu_cnt_q <= lu_cnt_d;
    end
  end

  // Outputs are combinational, so gate them with reset to keep them quiet
  // while Rst_N is low regardless of what the inputs are doing.
  assign ctrl_out        = Rst_N ? ctrl : '0;
  assign Do_Stall        = ctrl_out.stall;
  assign Is_Branch_Taken = ctrl_out.taken;
  assign Flush_If_Id     = ctrl_out.flush;
  assign Bubble_Id_Ex    = ctrl_out.bubble;

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .Clk   (Clk),
    .Rst_N (Rst_N),
    .Clr   (Perf_Clr),
    .Inc   (ctrl_out.stall),
    .Count (Stall_Count)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .Clk   (Clk),
    .Rst_N (Rst_N),
    .Clr   (Perf_Clr),
    .Inc   (ctrl_out.taken),
    .Count (Flush_Count)
  );

endmodule

// File: tb/tb_pc_hazard_ctrl.sv
// Scoreboard bench for pc_hazard_ctrl: two instances (3-cycle and 1-cycle
// load-use) share stimulus; expected responses are queued and checked per cycle.
module tb_pc_hazard_ctrl;

  typedef struct {
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
    logic u1, u2, mr, bv, bc, busy, clr, rst_n;
  } vec_t;

  typedef struct {
    string      name;
    bit         inv_only;
    logic [3:0] a;
    bit         chk_b;
    logic [3:0] b;
    bit         chk_cnt;
    logic [7:0] sca, fca, scb, fcb;
  } exp_t;

  logic       clk;
  logic       rst_n;
  logic [4:0] id_rs1, id_rs2, ex_rd;
  logic       id_uses_rs1, id_uses_rs2, ex_mem_read;
  logic       ex_branch_valid, ex_branch_cond, dmem_busy, perf_clr;

  logic       a_stall, a_taken, a_flush, a_bubble;
  logic       b_stall, b_taken, b_flush, b_bubble;
  logic [7:0] a_sc, a_fc, b_sc, b_fc;

  int n_tests = 0;
  int n_fail  = 0;
  exp_t exp_q[$];

  pc_hazard_ctrl #(.LOAD_USE_CYCLES(3), .CNT_W(8)) u_dut_a (
    .Clk(clk), .Rst_N(rst_n),
    .Id_Rs1(id_rs1), .Id_Rs2(id_rs2), .Id_Uses_Rs1(id_uses_rs1), .Id_Uses_Rs2(id_uses_rs2),
    .Ex_Rd(ex_rd), .Ex_Mem_Read(ex_mem_read),
    .Ex_Branch_Valid(ex_branch_valid), .Ex_Branch_Cond(ex_branch_cond),
    .Dmem_Busy(dmem_busy), .Perf_Clr(perf_clr),
    .Do_Stall(a_stall), .Is_Branch_Taken(a_taken), .Flush_If_Id(a_flush), .Bubble_Id_Ex(a_bubble),
    .Stall_Count(a_sc), .Flush_Count(a_fc)
  );

  pc_hazard_ctrl #(.LOAD_USE_CYCLES(1), .CNT_W(8)) u_dut_b (
    .Clk(clk), .Rst_N(rst_n),
    .Id_Rs1(id_rs1), .Id_Rs2(id_rs2), .Id_Uses_Rs1(id_uses_rs1), .Id_Uses_Rs2(id_uses_rs2),
    .Ex_Rd(ex_rd), .Ex_Mem_Read(ex_mem_read),
    .Ex_Branch_Valid(ex_branch_valid), .Ex_Branch_Cond(ex_branch_cond),
    .Dmem_Busy(dmem_busy), .Perf_Clr(perf_clr),
    .Do_Stall(b_stall), .Is_Branch_Taken(b_taken), .Flush_If_Id(b_flush), .Bubble_Id_Ex(b_bubble),
    .Stall_Count(b_sc), .Flush_Count(b_fc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Control nibble order: {stall, taken, flush, bubble}
  localparam logic [3:0] C_NONE = 4'b0000;
  localparam logic [3:0] C_LU   = 4'b1001;
  localparam logic [3:0] C_HOLD = 4'b1000;
  localparam logic [3:0] C_BR   = 4'b0111;

  function automatic vec_t mk(input logic busy, input logic bv, input logic bc,
                              input logic mr, input logic [4:0] rd,
                              input logic u1, input logic [4:0] rs1,
                              input logic u2, input logic [4:0] rs2,
                              input logic clr, input logic rstn);
    vec_t v;
    v.busy = busy; v.bv = bv; v.bc = bc; v.mr = mr; v.rd = rd;
    v.u1 = u1; v.rs1 = rs1; v.u2 = u2; v.rs2 = rs2; v.clr = clr; v.rst_n = rstn;
    return v;
  endfunction

  function automatic vec_t idle();
    return mk(0, 0, 0, 0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 1);
  endfunction

  function automatic vec_t lu(input logic [4:0] r);
    return mk(0, 0, 0, 1, r, 1, r, 0, 5'd0, 0, 1);
  endfunction

  function automatic vec_t busy_v(input logic bv, input logic bc, input logic clr);
    return mk(1, bv, bc, 0, 5'd0, 0, 5'd0, 0, 5'd0, clr, 1);
  endfunction

  function automatic exp_t E(input string name, input logic [3:0] a,
                             input bit chk_b, input logic [3:0] b);
    exp_t e;
    e.name = name; e.inv_only = 1'b0; e.a = a; e.chk_b = chk_b; e.b = b;
    e.chk_cnt = 1'b0; e.sca = '0; e.fca = '0; e.scb = '0; e.fcb = '0;
    return e;
  endfunction

  function automatic exp_t EC(input string name, input logic [3:0] a,
                              input bit chk_b, input logic [3:0] b,
                              input logic [7:0] sca, input logic [7:0] fca,
                              input logic [7:0] scb, input logic [7:0] fcb);
    exp_t e;
    e = E(name, a, chk_b, b);
    e.chk_cnt = 1'b1; e.sca = sca; e.fca = fca; e.scb = scb; e.fcb = fcb;
    return e;
  endfunction

  task automatic apply(input vec_t v);
    rst_n           = v.rst_n;
    id_rs1          = v.rs1;
    id_rs2          = v.rs2;
    id_uses_rs1     = v.u1;
    id_uses_rs2     = v.u2;
    ex_rd           = v.rd;
    ex_mem_read     = v.mr;
    ex_branch_valid = v.bv;
    ex_branch_cond  = v.bc;
    dmem_busy       = v.busy;
    perf_clr        = v.clr;
  endtask

  task automatic step(input vec_t v, input exp_t e);
    @(posedge clk);
    #1;
    apply(v);
    exp_q.push_back(e);
  endtask

  // Monitor: outputs are combinational, so compare mid-cycle on the falling edge.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      logic [3:0] got_a, got_b;
      e = exp_q.pop_front();
      got_a = {a_stall, a_taken, a_flush, a_bubble};
      got_b = {b_stall, b_taken, b_flush, b_bubble};
      if (e.inv_only) begin
        n_tests++;
        if ((a_stall && a_taken) || (b_stall && b_taken)) begin
          n_fail++;
          $display("FAIL %s: {taken,stall} a=%b%b b=%b%b, neither may be 11",
                   e.name, a_taken, a_stall, b_taken, b_stall);
        end
      end else begin
        n_tests++;
        if (got_a !== e.a) begin
          n_fail++;
          $display("FAIL %s: dut_a ctrl got %b want %b", e.name, got_a, e.a);
        end
        if (e.chk_b) begin
          n_tests++;
          if (got_b !== e.b) begin
            n_fail++;
            $display("FAIL %s: dut_b ctrl got %b want %b", e.name, got_b, e.b);
          end
        end
        if (e.chk_cnt) begin
          n_tests++;
          if ({a_sc, a_fc, b_sc, b_fc} !== {e.sca, e.fca, e.scb, e.fcb}) begin
            n_fail++;
            $display("FAIL %s_cnt: a_sc/a_fc/b_sc/b_fc got %0d/%0d/%0d/%0d want %0d/%0d/%0d/%0d",
                     e.name, a_sc, a_fc, b_sc, b_fc, e.sca, e.fca, e.scb, e.fcb);
          end
        end
      end
    end
  end

  initial begin
    apply(mk(0, 0, 0, 0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0));

    // Reset: outputs gated low even with a hazard on the inputs.
    step(mk(0, 0, 0, 1, 5'd5, 1, 5'd5, 0, 5'd0, 0, 0), EC("rst_hold", C_NONE, 1, C_NONE, 0, 0, 0, 0));
    step(idle(), EC("idle_after_rst", C_NONE, 1, C_NONE, 0, 0, 0, 0));

    // Load-use: 3 stall cycles on A, exactly 1 on B.
    step(lu(5'd5), E("lu_first", C_LU, 1, C_LU));
    step(idle(),   EC("lu_c2", C_LU, 1, C_NONE, 1, 0, 1, 0));
    step(idle(),   E("lu_c3", C_LU, 1, C_NONE));
    step(idle(),   EC("lu_done", C_NONE, 1, C_NONE, 3, 0, 1, 0));

    // x0 destination never hazards.
    step(mk(0, 0, 0, 1, 5'd0, 1, 5'd0, 1, 5'd0, 0, 1), E("lu_x0", C_NONE, 1, C_NONE));
    step(idle(), EC("x0_cnt", C_NONE, 1, C_NONE, 3, 0, 1, 0));

    // Taken branch beats a concurrent load-use (via rs2).
    step(mk(0, 1, 1, 1, 5'd7, 0, 5'd0, 1, 5'd7, 0, 1), E("br_over_lu", C_BR, 1, C_BR));
    step(idle(), EC("br_cnt", C_NONE, 1, C_NONE, 3, 1, 1, 1));

    // Not-taken branch leaves the load-use in charge.
    step(mk(0, 1, 0, 1, 5'd9, 1, 5'd9, 0, 5'd0, 0, 1), E("nt_lu", C_LU, 1, C_LU));
    step(idle(), E("nt_lu2", C_LU, 1, C_NONE));
    step(idle(), E("nt_lu3", C_LU, 1, C_NONE));
    step(idle(), EC("nt_lu_end", C_NONE, 1, C_NONE, 6, 1, 2, 1));

    // Branch held across a 4-cycle memory wait redirects once on exit.
    for (int i = 0; i < 4; i++) step(busy_v(1, 1, 0), E("memw_hold", C_HOLD, 1, C_HOLD));
    step(mk(0, 1, 1, 0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 1), E("memw_exit", C_BR, 1, C_BR));
    step(idle(), EC("memw_cnt", C_NONE, 1, C_NONE, 10, 2, 6, 2));

    // Busy inside LU_STALL freezes the count; a branch there is ignored.
    step(lu(5'd3), E("lub_first", C_LU, 1, C_LU));
    step(busy_v(0, 0, 0), E("lub_busy", C_LU, 1, C_HOLD));
    step(idle(), E("lub_resume", C_LU, 1, C_NONE));
    step(mk(0, 1, 1, 0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 1), E("lub_br_ignored", C_LU, 1, C_BR));
    step(idle(), E("lub_done", C_NONE, 1, C_NONE));
    step(idle(), EC("lub_cnt", C_NONE, 1, C_NONE, 14, 2, 8, 3));

    // Async reset while A sits in LU_STALL.
    step(lu(5'd4), E("rst_lu_first", C_LU, 1, C_LU));
    step(mk(0, 0, 0, 1, 5'd4, 1, 5'd4, 0, 5'd0, 0, 0), EC("rst_in_lu", C_NONE, 1, C_NONE, 0, 0, 0, 0));
    step(idle(), EC("rst_release", C_NONE, 1, C_NONE, 0, 0, 0, 0));
    step(idle(), E("rst_run", C_NONE, 1, C_NONE));

    // Perf_Clr together with a stall: count reads 0 next cycle.
    step(busy_v(0, 0, 0), E("clr_busy1", C_HOLD, 1, C_HOLD));
    step(busy_v(0, 0, 1), EC("clr_busy2", C_HOLD, 1, C_HOLD, 1, 0, 1, 0));
    step(idle(), EC("clr_after", C_NONE, 1, C_NONE, 0, 0, 0, 0));

    // Saturation: 2^8+5 stall cycles.
    for (int i = 0; i < 261; i++) step(busy_v(0, 0, 0), E("sat_busy", C_HOLD, 1, C_HOLD));
    step(idle(), EC("sat_hold", C_NONE, 1, C_NONE, 255, 0, 255, 0));
    step(busy_v(0, 0, 0), E("sat_more", C_HOLD, 1, C_HOLD));
    step(idle(), EC("sat_still", C_NONE, 1, C_NONE, 255, 0, 255, 0));

    // Random traffic: invariant only.
    for (int i = 0; i < 10000; i++) begin
      vec_t v;
      exp_t e;
      v = mk(($urandom % 6) == 0, ($urandom % 3) == 0, 1'($urandom),
             1'($urandom), 5'($urandom_range(0, 3)),
             1'($urandom), 5'($urandom_range(0, 3)),
             1'($urandom), 5'($urandom_range(0, 3)),
             ($urandom % 64) == 0, 1);
      e = E("rand_inv", C_NONE, 0, C_NONE);
      e.inv_only = 1'b1;
      step(v, e);
    end

    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge clk);
    if (exp_q.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain: %0d expected responses left, want 0", exp_q.size());
    end
    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
